// File: rtl/ckt_core.sv
// Six-input gate-level benchmark cone with registered inputs and a single
// stuck-at fault injector for fault-simulation flows.
module ckt_core #(
  parameter int unsigned OUTPUT_REG = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       fault_en,
  input  logic [3:0] fault_sel,
  input  logic       fault_val,
  output logic       y
);

  logic ra, rb, rc, rd, re, rf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ra, rb, rc, rd, re, rf} <= 6'b0;
    end else begin
      {ra, rb, rc, rd, re, rf} <= {a, b, c, d, e, f};
    end
  end

  // One-hot fault site; indices 14 and 15 decode to nothing.
  logic [13:0] faultHit;

  always_comb begin
    faultHit = '0;
    for (int i = 0; i < 14; i++) begin
      faultHit[i] = fault_en && (fault_sel == 4'(i));
    end
  end

  logic sa, sb, sc, sd, se, sf;
  logic n1, n2, n3, n4, n5, n6, n7, yc;

  // Each net is overridden at its driver so every fanout sees the stuck value.
  always_comb begin
    sa = faultHit[0]  ? fault_val : ra;
    sb = faultHit[1]  ? fault_val : rb;
    sc = faultHit[2]  ? fault_val : rc;
    sd = faultHit[3]  ? fault_val : rd;
    se = faultHit[4]  ? fault_val : re;
    sf = faultHit[5]  ? fault_val : rf;
    n1 = faultHit[6]  ? fault_val : ~(sa & sb);
    n2 = faultHit[7]  ? fault_val : ~(sc | sd);
    n3 = faultHit[8]  ? fault_val : (se & sf);
    n4 = faultHit[9]  ? fault_val : (n1 | n2);
    n5 = faultHit[10] ? fault_val : ~(n2 & n3);
    n6 = faultHit[11] ? fault_val : (n4 & n5);
    n7 = faultHit[12] ? fault_val : ~(n1 | n3);
    yc = faultHit[13] ? fault_val : (n6 | n7);
  end

  if (OUTPUT_REG != 0) begin : gen_out_reg
    logic yQ;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        yQ <= 1'b0;
      end else begin
        yQ <= yc;
      end
    end

    assign y = yQ;
  end else begin : gen_out_comb
    assign y = yc;
  end

endmodule

// File: tb/tb_ckt_core.sv
// Scoreboard bench for ckt_core: one combinational-output and one registered-output
// instance share stimulus; a monitor pops queued expectations as outputs become due.
module tb_ckt_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b, c, d, e, f;
  logic       fault_en;
  logic [3:0] fault_sel;
  logic       fault_val;
  logic       y0, y1;

  ckt_core #(.OUTPUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .fault_en(fault_en), .fault_sel(fault_sel), .fault_val(fault_val), .y(y0)
  );

  ckt_core #(.OUTPUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .fault_en(fault_en), .fault_sel(fault_sel), .fault_val(fault_val), .y(y1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       exp;
    string      name;
    int         fidx;
    logic [5:0] vec;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          nCmp = 0;
  int          nErr = 0;
  logic [63:0] synd[28];

  function automatic logic fx(logic en, logic [3:0] sel, logic val, int idx, logic v);
    return (en && sel == 4'(idx)) ? val : v;
  endfunction

  // Reference cone written straight from the gate list.
  function automatic logic model(logic [5:0] v, logic en, logic [3:0] sel, logic val);
    logic pa, pb, pc, pd, pe, pf, m1, m2, m3, m4, m5, m6, m7;
    pa = fx(en, sel, val, 0, v[5]);
    pb = fx(en, sel, val, 1, v[4]);
    pc = fx(en, sel, val, 2, v[3]);
    pd = fx(en, sel, val, 3, v[2]);
    pe = fx(en, sel, val, 4, v[1]);
    pf = fx(en, sel, val, 5, v[0]);
    m1 = fx(en, sel, val, 6, !(pa && pb));
    m2 = fx(en, sel, val, 7, !(pc || pd));
    m3 = fx(en, sel, val, 8, pe && pf);
    m4 = fx(en, sel, val, 9, m1 || m2);
    m5 = fx(en, sel, val, 10, !(m2 && m3));
    m6 = fx(en, sel, val, 11, m4 && m5);
    m7 = fx(en, sel, val, 12, !(m1 || m3));
    return fx(en, sel, val, 13, m6 || m7);
  endfunction

  task automatic check(string name, logic act, logic exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got y=%b, expected y=%b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(logic [5:0] v, logic en, logic [3:0] sel, logic val, logic exp,
                      string name, logic chk1, int fidx);
    @(negedge clk);
    {a, b, c, d, e, f} = v;
    fault_en  = en;
    fault_sel = sel;
    fault_val = val;
    q0.push_back('{cyc + 1, exp, name, fidx, v});
    if (chk1) q1.push_back('{cyc + 2, exp, {name, "_reg"}, -1, v});
  endtask

  task automatic drain();
    int budget = 10;
    while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      nErr++;
      $display("FAIL drain: %0d/%0d entries pending, expected 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  always @(posedge clk) begin
    exp_t ent;
    #1;
    while (q0.size() > 0 && q0[0].due <= cyc) begin
      ent = q0.pop_front();
      if (ent.due < cyc) check({ent.name, "_late"}, 1'b0, 1'b1);
      else               check(ent.name, y0, ent.exp);
      if (ent.fidx >= 0) synd[ent.fidx][ent.vec] = y0 ^ model(ent.vec, 1'b0, 4'd0, 1'b0);
    end
    while (q1.size() > 0 && q1[0].due <= cyc) begin
      ent = q1.pop_front();
      if (ent.due < cyc) check({ent.name, "_late"}, 1'b0, 1'b1);
      else               check(ent.name, y1, ent.exp);
    end
  end

  initial begin
    int nDet;
    for (int i = 0; i < 28; i++) synd[i] = '0;
    rst_n = 1'b0;
    {a, b, c, d, e, f} = 6'b0;
    fault_en = 1'b0;
    fault_sel = 4'd0;
    fault_val = 1'b0;
    #1;
    check("reset_y_comb", y0, 1'b1);
    check("reset_y_reg", y1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fault-free truth check, both latencies.
    send(6'b000000, 1'b0, 4'd0, 1'b0, 1'b1, "tt_000000", 1'b1, -1);
    send(6'b111111, 1'b0, 4'd0, 1'b0, 1'b0, "tt_111111", 1'b1, -1);
    send(6'b110011, 1'b0, 4'd0, 1'b0, 1'b0, "tt_110011", 1'b1, -1);
    send(6'b110000, 1'b0, 4'd0, 1'b0, 1'b1, "tt_110000", 1'b1, -1);
    send(6'b111100, 1'b0, 4'd0, 1'b0, 1'b1, "tt_111100", 1'b1, -1);

    // Unmapped fault sites must look fault-free.
    for (int s = 14; s < 16; s++) begin
      for (int v = 0; v < 64; v++) begin
        send(6'(v), 1'b1, 4'(s), 1'(v), model(6'(v), 1'b0, 4'd0, 1'b0),
             $sformatf("null_sel%0d_v%0d", s, v), 1'b1, -1);
      end
    end
    drain();

    // Asynchronous reset between edges.
    fault_en = 1'b0;
    send(6'b000000, 1'b0, 4'd0, 1'b0, 1'b1, "pre_000000", 1'b1, -1);
    @(negedge clk);
    {a, b, c, d, e, f} = 6'b111111;
    @(posedge clk);
    #3;
    check("pre_rst_y_comb", y0, 1'b0);
    check("pre_rst_y_reg", y1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_y_comb", y0, 1'b1);
    check("async_rst_y_reg", y1, 1'b0);
    fault_en = 1'b1;
    fault_sel = 4'd13;
    fault_val = 1'b0;
    #1;
    check("rst_fault_yc_sa0", y0, 1'b0);
    fault_en = 1'b0;
    #1;
    check("rst_fault_removed", y0, 1'b1);
    {a, b, c, d, e, f} = 6'b000000;
    @(negedge clk);
    rst_n = 1'b1;
    send(6'b000000, 1'b0, 4'd0, 1'b0, 1'b1, "post_000000", 1'b1, -1);
    send(6'b110011, 1'b0, 4'd0, 1'b0, 1'b0, "post_110011", 1'b1, -1);
    drain();

    // Directed faults, hand-computed.
    send(6'b110011, 1'b1, 4'd10, 1'b1, 1'b1, "n5_sa1_110011", 1'b0, -1);
    send(6'b000000, 1'b1, 4'd10, 1'b1, 1'b1, "n5_sa1_000000", 1'b0, -1);
    send(6'b000000, 1'b1, 4'd13, 1'b0, 1'b0, "yc_sa0_000000", 1'b0, -1);
    send(6'b111111, 1'b1, 4'd0, 1'b0, 1'b1, "ra_sa0_111111", 1'b0, -1);

    // Exhaustive single stuck-at sweep.
    for (int fi = 0; fi < 28; fi++) begin
      for (int v = 0; v < 64; v++) begin
        send(6'(v), 1'b1, 4'(fi / 2), 1'(fi % 2),
             model(6'(v), 1'b1, 4'(fi / 2), 1'(fi % 2)),
             $sformatf("sweep_sel%0d_sa%0d_v%0d", fi / 2, fi % 2, v), 1'b0, fi);
      end
    end
    drain();

    nDet = 0;
    for (int fi = 0; fi < 28; fi++) begin
      if (synd[fi] != 64'd0) nDet++;
      $display("fault sel=%0d sa%0d syndrome=%016h", fi / 2, fi % 2, synd[fi]);
    end
    $display("detectable faults: %0d of 28", nDet);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr + 1);
    $fatal(1);
  end

endmodule

// File: doc/ckt_core.md
Name: ckt_core

Overview:
- Six-input, single-output gate-level benchmark logic cone, used as the circuit under fault simulation (golden copy and faulty copy run side by side).
- Primary inputs are registered; the logic cone is an explicit netlist of named two-input gates.
- A built-in single stuck-at fault injector can force any one net to 0 or 1, so fault-dictionary flows can run in plain RTL simulation.

Parameters:
- OUTPUT_REG, 0, 0 = y driven combinationally from registered inputs (latency 1); 1 = y also registered (latency 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- a  input  1  primary input, MSB of test vector {a,b,c,d,e,f}
- b  input  1  primary input
- c  input  1  primary input
- d  input  1  primary input
- e  input  1  primary input
- f  input  1  primary input, LSB
- fault_en  input  1  1 = apply stuck-at fault on net fault_sel
- fault_sel  input  4  net index of the fault site (map below)
- fault_val  input  1  stuck-at value, 0 or 1
- y  output  1  circuit output

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock. While rst_n=0, all six input registers (ra..rf) are cleared to 0 immediately. When OUTPUT_REG=1, the y register is also cleared to 0.
- Input capture: on each rising clk with rst_n=1, {ra..rf} <= {a..f}.
- Netlist, evaluated combinationally on the registered inputs:
  - n1 = NAND(ra,rb)
  - n2 = NOR(rc,rd)
  - n3 = AND(re,rf)
  - n4 = OR(n1,n2)
  - n5 = NAND(n2,n3)
  - n6 = AND(n4,n5)
  - n7 = NOR(n1,n3)
  - yc = OR(n6,n7)
- Net index map for fault_sel:
  - 0..5 = ra,rb,rc,rd,re,rf (fault acts on the register output, i.e. the gate-side stem)
  - 6..12 = n1..n7
  - 13 = yc
  - 14 and 15 = no fault (behave as if fault_en=0)
- Fault semantics:
  - When fault_en=1 and fault_sel<=13, the selected net's value is replaced by fault_val for every fanout of that net.
  - All other nets evaluate normally.
  - Exactly one fault site at a time.
  - Fault controls are not registered: they take effect combinationally, with no clock needed. Changing them mid-operation updates yc within the same cycle.
- Output:
  - OUTPUT_REG=0: y = yc. Latency is 1 clock from input presentation. During reset y is therefore 1 for the fault-free circuit, since all-zero inputs give yc=1.
  - OUTPUT_REG=1: y <= yc on each rising clk. Latency is 2 clocks. Reset value is 0.
- Reset asserted mid-operation: registers clear at once; y follows the rules above. The fault controls still apply while reset is asserted.
- No X propagation from fault_sel: every value 0..15 has defined behaviour.

Test Plan:
- Fault-free truth check, OUTPUT_REG=0, fault_en=0. Apply each vector {a..f} and read y one clock later:
  - 000000 -> y=1
  - 111111 -> y=0
  - 110011 -> y=0
  - 110000 -> y=1
  - 111100 -> y=1
- Fault n5 (sel=10) stuck-at-1 with vector 110011 -> y=1, versus fault-free 0 (fault detected). Same fault with vector 000000 -> y=1, equal to fault-free (not detected).
- Fault yc (sel=13) stuck-at-0 with vector 000000 -> y=0. Fault ra (sel=0) stuck-at-0 with vector 111111 -> n1=1, y=1.
- Fault controls fault_sel=14 or 15 with fault_en=1 -> outputs identical to fault-free for all 64 vectors.
- Reset: drive 111111 and clock once (y=0), then assert rst_n=0 asynchronously between edges:
  - OUTPUT_REG=0: y returns to 1 without a clock edge.
  - OUTPUT_REG=1: y goes to 0 immediately.
  - Release reset, apply 110011 -> y=0 after 1 clock (OUTPUT_REG=0) or after 2 clocks (OUTPUT_REG=1).
- Exhaustive sweep: all 64 vectors x 28 single faults (14 nets x stuck-at-0/1). Compare against a reference model and build a per-fault syndrome bit string.
